iq_wakeup_select: RTL and testbench
===================================

// Module: iq_wakeup_select
// PURPOSE
//  Wakeup/select scheduler for one issue queue. It tracks slot occupancy, per-source ready bits and relative age.
//  It wakes sources from physical-register broadcast tags, selects the oldest fully-ready slot and hands its index to the FU.
//  Entry payload lives in the queue's payload array; this block only produces write slot (alloc) and read slot (issue) indices.
//  One instance sits in front of each alu/mem/br/mul issue queue, between rename write and execute.
// PARAMETERS
//  QLEN    8  number of queue slots (power of 2, >=2)
//  PREG_W  6  physical register id width
//  WAKE_N  4  number of wakeup broadcast ports
// PORTS
//  clk             in   1                   clock
//  reset           in   1                   synchronous, active-high reset
//  flush           in   1                   synchronous squash of all slots
//  alloc_valid     in   1                   new entry offered
//  alloc_ready     out  1                   a free slot exists (registered state only)
//  alloc_slot      out  $clog2(QLEN)        slot the payload must be written to this cycle
//  alloc_src1_pid  in   PREG_W              src1 physical id
//  alloc_src1_rdy  in   1                   src1 already ready (or unused)
//  alloc_src2_pid  in   PREG_W              src2 physical id
//  alloc_src2_rdy  in   1                   src2 already ready (or unused)
//  wake_valid      in   WAKE_N              broadcast valid per port
//  wake_pid        in   WAKE_N*PREG_W       broadcast physical id per port
//  issue_valid     out  1                   a ready slot is selected
//  issue_slot      out  $clog2(QLEN)        selected slot index
//  issue_ready     in   1                   FU accepts issue this cycle
//  count           out  $clog2(QLEN)+1      occupied slots
//  empty           out  1                   count==0
// BEHAVIOUR
//  - Reset/flush next state: all valid=0, ready bits=0, age matrix=0.
//    Outputs after reset: issue_valid=0, alloc_ready=1, alloc_slot=0, count=0, empty=1.
//  - Per slot: valid, r1, r2, p1, p2. Age matrix older[i][j]=1 means slot i was allocated before slot j.
//  - Alloc fires on alloc_valid&alloc_ready.
//    alloc_slot = lowest-index free slot per registered valid bits.
//    At the edge: valid=1, pids stored, older[j][k]=1 for every valid j, older[k][*]=0.
//  - Alloc bypass: rK = alloc_srcK_rdy | (any wake_valid[w] with wake_pid[w]==alloc_srcK_pid in the same cycle).
//  - Wakeup: every valid slot with rK=0 and a matching valid wake port sets rK=1 at the edge.
//    A slot woken in cycle t is selectable from t+1; wakeup never reaches select combinationally.
//  - Select (combinational from registers): cand[i] = valid&r1&r2.
//    Slot i is picked iff cand[i] and no cand[j] with older[j][i].
//    issue_valid = |cand; issue_slot = picked index; issue_slot = 0 when !issue_valid.
//  - Issue fires on issue_valid&issue_ready; the picked slot's valid clears at the edge.
//    issue_slot must remain stable while issue_valid&!issue_ready, except a newly ready older slot may preempt.
//  - A slot freed in cycle t is allocatable in t+1, never in t. Simultaneous alloc and issue in one cycle: count unchanged.
//  - full (count==QLEN): alloc_ready=0; alloc_valid is ignored (no state change).
//  - flush overrides alloc, issue and wakeup in the same cycle. flush has priority below reset only.
//  - Ages are always consistent: exactly one total order over valid slots; freed slots' rows and columns are don't-care.
//  - Wake ports carrying the same pid are legal (idempotent).
// STRUCTURE
//  - issue_pkg: preg_id_t (PREG_W), wake_req_t {valid, pid}, iq_sched_entry_t {valid, r1, r2, p1, p2}.
//  - Sub-module iq_age_matrix: QLEN x QLEN older bits, alloc/free update, oldest-of-vector one-hot pick.
//  - Top: slot registers, wakeup CAM compare, free-slot priority encoder, counters.
// TESTING
//  1 reset, 3 allocs (src rdy=1,1) into slots 0,1,2, issue_ready=1
//    -> issue_slot 0,1,2 on consecutive cycles; count 3->0; empty=1.
//  2 alloc slot0 with src1 pid=5 rdy=0; wake pid 5 at t+2
//    -> issue_valid=0 through t+2, issue_valid=1 with slot 0 at t+3.
//  3 alloc with src1 pid=9 rdy=0 while wake_pid[2]=9 in the same cycle
//    -> slot ready immediately; issue_valid=1 the next cycle.
//  4 fill 8 slots, none ready -> alloc_ready=0, count=8; extra alloc_valid ignored.
//    Wake the youngest, then the oldest in a later cycle, issue_ready=0 -> issue_slot switches to the oldest.
//  5 free slot 3 then issue slot 3 and alloc in the same cycle with count=8
//    -> alloc not accepted that cycle; next cycle alloc_slot=3.
//  6 5 valid slots, flush asserted with alloc_valid&issue_ready
//    -> next cycle count=0, issue_valid=0, alloc_ready=1, no slot issued.

Source files
------------

// File: rtl/iq_wakeup_select_pkg.sv
// Shared types for the issue-queue wakeup/select scheduler.
// Only the pid width fixes a type; queue depth and port count are module parameters.
package issue_pkg;

  localparam int IQ_QLEN   = 8;
  localparam int IQ_PREG_W = 6;
  localparam int IQ_WAKE_N = 4;

  typedef logic [IQ_PREG_W-1:0] preg_id_t;

  typedef struct packed {
    logic     valid;
    preg_id_t pid;
  } wake_req_t;

  typedef struct packed {
    logic     valid;
    logic     r1;
    logic     r2;
    preg_id_t p1;
    preg_id_t p2;
  } iq_sched_entry_t;

endpackage

// File: rtl/iq_age_matrix.sv
// Relative-age tracker for the issue queue slots.
// older[i][j]=1 means slot i was allocated before slot j; grant is the oldest requester.
module iq_age_matrix #(
  parameter int QLEN = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [QLEN-1:0] alloc_oh,
  input  logic [QLEN-1:0] valid,
  input  logic [QLEN-1:0] req,
  output logic [QLEN-1:0] grant
);

  logic [QLEN-1:0] older [QLEN];

  // A new slot is younger than every currently valid slot; its own row starts empty.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < QLEN; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < QLEN; i++) begin
        for (int j = 0; j < QLEN; j++) begin
          if (alloc_oh[i]) older[i][j] <= 1'b0;
          else if (alloc_oh[j]) older[i][j] <= valid[i];
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < QLEN; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < QLEN; j++) blocked = blocked | (req[j] & older[j][i]);
      grant[i] = req[i] & ~blocked;
    end
  end

endmodule

// File: rtl/iq_wakeup_select.sv
// Wakeup/select scheduler for one issue queue: tracks slot occupancy and source
// readiness, wakes sources from broadcast tags and picks the oldest ready slot.
module iq_wakeup_select
  import issue_pkg::*;
#(
  parameter int QLEN   = IQ_QLEN,
  parameter int PREG_W = IQ_PREG_W,
  parameter int WAKE_N = IQ_WAKE_N
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic [$clog2(QLEN)-1:0]    alloc_slot,
  input  logic [PREG_W-1:0]          alloc_src1_pid,
  input  logic                       alloc_src1_rdy,
  input  logic [PREG_W-1:0]          alloc_src2_pid,
  input  logic                       alloc_src2_rdy,
  input  logic [WAKE_N-1:0]          wake_valid,
  input  logic [WAKE_N*PREG_W-1:0]   wake_pid,
  output logic                       issue_valid,
  output logic [$clog2(QLEN)-1:0]    issue_slot,
  input  logic                       issue_ready,
  output logic [$clog2(QLEN):0]      count,
  output logic                       empty
);

  localparam int IDX_W = $clog2(QLEN);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(QLEN);

  // Handshakes: a transfer happens on a cycle where valid & ready are both high
  // at the clock edge; ready/valid outputs here depend only on registered state.

  iq_sched_entry_t             slots [QLEN];
  wake_req_t [WAKE_N-1:0]      wake;
  logic [QLEN-1:0]             valid_vec, cand, grant, alloc_oh, hit1, hit2;
  logic                        alloc_hit1, alloc_hit2, alloc_fire, issue_fire;

  function automatic logic wake_hit(input preg_id_t pid, input wake_req_t [WAKE_N-1:0] ports);
    logic h;
    h = 1'b0;
    for (int w = 0; w < WAKE_N; w++) h = h | (ports[w].valid && ports[w].pid == pid);
    return h;
  endfunction

  always_comb begin
    for (int w = 0; w < WAKE_N; w++) begin
      wake[w].valid = wake_valid[w];
      wake[w].pid   = wake_pid[w*PREG_W +: PREG_W];
    end
  end

  always_comb begin
    for (int i = 0; i < QLEN; i++) begin
      valid_vec[i] = slots[i].valid;
      cand[i]      = slots[i].valid & slots[i].r1 & slots[i].r2;
      hit1[i]      = wake_hit(slots[i].p1, wake);
      hit2[i]      = wake_hit(slots[i].p2, wake);
    end
    alloc_hit1 = wake_hit(alloc_src1_pid, wake);
    alloc_hit2 = wake_hit(alloc_src2_pid, wake);
  end

  always_comb begin
    alloc_slot = '0;
    for (int i = QLEN - 1; i >= 0; i--) if (!valid_vec[i]) alloc_slot = IDX_W'(i);
  end

  assign alloc_ready = (count != FULL_CNT);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign issue_valid = |cand;
  assign issue_fire  = issue_valid & issue_ready;
  assign empty       = (count == '0);

  always_comb begin
    alloc_oh = '0;
    if (alloc_fire) alloc_oh[alloc_slot] = 1'b1;
  end

  always_comb begin
    issue_slot = '0;
    for (int i = 0; i < QLEN; i++) if (grant[i]) issue_slot = IDX_W'(i);
  end

  iq_age_matrix #(.QLEN(QLEN)) u_age (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .alloc_oh (alloc_oh),
    .valid    (valid_vec),
    .req      (cand),
    .grant    (grant)
  );

  // Wakeups land in registers only, so a newly woken slot competes from the next cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < QLEN; i++) slots[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < QLEN; i++) begin
        if (alloc_oh[i]) begin
          slots[i].valid <= 1'b1;
          slots[i].r1    <= alloc_src1_rdy | alloc_hit1;
          slots[i].r2    <= alloc_src2_rdy | alloc_hit2;
          slots[i].p1    <= alloc_src1_pid;
          slots[i].p2    <= alloc_src2_pid;
        end else if (slots[i].valid) begin
          if (issue_fire && grant[i]) slots[i].valid <= 1'b0;
          if (hit1[i]) slots[i].r1 <= 1'b1;
          if (hit2[i]) slots[i].r2 <= 1'b1;
        end
      end
      count <= count + {{IDX_W{1'b0}}, alloc_fire} - {{IDX_W{1'b0}}, issue_fire};
    end
  end

endmodule

// File: tb/tb_iq_wakeup_select.sv
// Directed bench for iq_wakeup_select: expected issue slots are queued as stimulus
// is driven and compared whenever the scheduler hands a slot to the FU.
module tb_iq_wakeup_select;

  localparam int QLEN   = 8;
  localparam int PREG_W = 6;
  localparam int WAKE_N = 4;
  localparam int IDX_W  = 3;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     flush = 1'b0;
  logic                     alloc_valid = 1'b0;
  logic                     alloc_ready;
  logic [IDX_W-1:0]         alloc_slot;
  logic [PREG_W-1:0]        alloc_src1_pid = '0;
  logic                     alloc_src1_rdy = 1'b0;
  logic [PREG_W-1:0]        alloc_src2_pid = '0;
  logic                     alloc_src2_rdy = 1'b0;
  logic [WAKE_N-1:0]        wake_valid = '0;
  logic [WAKE_N*PREG_W-1:0] wake_pid = '0;
  logic                     issue_valid;
  logic [IDX_W-1:0]         issue_slot;
  logic                     issue_ready = 1'b0;
  logic [IDX_W:0]           count;
  logic                     empty;

  logic [IDX_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  iq_wakeup_select #(.QLEN(QLEN), .PREG_W(PREG_W), .WAKE_N(WAKE_N)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_slot     (alloc_slot),
    .alloc_src1_pid (alloc_src1_pid),
    .alloc_src1_rdy (alloc_src1_rdy),
    .alloc_src2_pid (alloc_src2_pid),
    .alloc_src2_rdy (alloc_src2_rdy),
    .wake_valid     (wake_valid),
    .wake_pid       (wake_pid),
    .issue_valid    (issue_valid),
    .issue_slot     (issue_slot),
    .issue_ready    (issue_ready),
    .count          (count),
    .empty          (empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [PREG_W-1:0] p1, input logic r1,
                           input logic [PREG_W-1:0] p2, input logic r2);
    alloc_valid    = v;
    alloc_src1_pid = p1;
    alloc_src1_rdy = r1;
    alloc_src2_pid = p2;
    alloc_src2_rdy = r2;
  endtask

  task automatic set_wake(input int port, input logic [PREG_W-1:0] pid);
    wake_valid[port] = 1'b1;
    wake_pid[port*PREG_W +: PREG_W] = pid;
  endtask

  task automatic clear_wake();
    wake_valid = '0;
    wake_pid   = '0;
  endtask

  // scoreboard: every accepted issue pops one expected slot
  always @(negedge clk) begin
    if (!reset && !flush && issue_valid === 1'b1 && issue_ready) begin
      if (exp_q.size() == 0) check("unexpected_issue", {31'd0, issue_valid}, 32'd0);
      else check("issue_slot", {29'd0, issue_slot}, {29'd0, exp_q.pop_front()});
    end
  end

  initial begin
    // reset
    repeat (2) tick();
    reset = 1'b0;
    check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    check("rst_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    check("rst_alloc_slot", {29'd0, alloc_slot}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);

    // 1: three ready allocs, then drain in order
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 6'(1 + i), 1'b1, 6'(10 + i), 1'b1);
      check("t1_alloc_slot", {29'd0, alloc_slot}, i);
      tick();
    end
    set_alloc(1'b0, '0, 1'b0, '0, 1'b0);
    check("t1_count3", {28'd0, count}, 32'd3);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    issue_ready = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      tick();
      check("t1_count_drain", {28'd0, count}, i);
    end
    issue_ready = 1'b0;
    check("t1_empty", {31'd0, empty}, 32'd1);
    check("t1_issue_valid", {31'd0, issue_valid}, 32'd0);

    // 2: src1 not ready, woken two cycles later
    set_alloc(1'b1, 6'd5, 1'b0, 6'd0, 1'b1);
    check("t2_alloc_slot", {29'd0, alloc_slot}, 32'd0);
    tick();
    set_alloc(1'b0, '0, 1'b0, '0, 1'b0);
    check("t2_idle_t1", {31'd0, issue_valid}, 32'd0);
    tick();
    set_wake(0, 6'd5);
    check("t2_idle_t2", {31'd0, issue_valid}, 32'd0);
    tick();
    clear_wake();
    check("t2_woken_valid", {31'd0, issue_valid}, 32'd1);
    check("t2_woken_slot", {29'd0, issue_slot}, 32'd0);
    exp_q.push_back(3'd0);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("t2_count", {28'd0, count}, 32'd0);

    // 3: alloc bypass on src1 (port 2) and src2 (duplicate ports 0 and 3)
    set_alloc(1'b1, 6'd9, 1'b0, 6'd1, 1'b1);
    set_wake(2, 6'd9);
    tick();
    clear_wake();
    set_alloc(1'b0, '0, 1'b0, '0, 1'b0);
    check("t3_byp1_valid", {31'd0, issue_valid}, 32'd1);
    exp_q.push_back(3'd0);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    set_alloc(1'b1, 6'd3, 1'b1, 6'd12, 1'b0);
    set_wake(0, 6'd12);
    set_wake(3, 6'd12);
    tick();
    clear_wake();
    set_alloc(1'b0, '0, 1'b0, '0, 1'b0);
    check("t3_byp2_valid", {31'd0, issue_valid}, 32'd1);
    check("t3_byp2_slot", {29'd0, issue_slot}, 32'd0);
    exp_q.push_back(3'd0);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;

    // 4: fill all slots with src1 pending; full ignores alloc; oldest preempts
    for (int i = 0; i < QLEN; i++) begin
      set_alloc(1'b1, 6'(16 + i), 1'b0, 6'd0, 1'b1);
      check("t4_alloc_slot", {29'd0, alloc_slot}, i);
      tick();
    end
    check("t4_count_full", {28'd0, count}, 32'd8);
    check("t4_alloc_ready", {31'd0, alloc_ready}, 32'd0);
    check("t4_none_ready", {31'd0, issue_valid}, 32'd0);
    set_alloc(1'b1, 6'd30, 1'b1, 6'd30, 1'b1);
    tick();
    set_alloc(1'b0, '0, 1'b0, '0, 1'b0);
    check("t4_full_ignored", {28'd0, count}, 32'd8);
    set_wake(1, 6'd23);
    tick();
    clear_wake();
    check("t4_young_slot", {29'd0, issue_slot}, 32'd7);
    tick();
    check("t4_stable_slot", {29'd0, issue_slot}, 32'd7);
    set_wake(0, 6'd16);
    tick();
    clear_wake();
    check("t4_preempt_slot", {29'd0, issue_slot}, 32'd0);

    // 5: issue while full and alloc together: alloc refused, slot reusable next cycle
    exp_q.push_back(3'd0); exp_q.push_back(3'd7);
    issue_ready = 1'b1;
    tick(); tick();
    issue_ready = 1'b0;
    check("t5_count6", {28'd0, count}, 32'd6);
    for (int i = 0; i < 2; i++) begin
      set_alloc(1'b1, 6'(40 + i), 1'b0, 6'd0, 1'b1);
      check("t5_refill_slot", {29'd0, alloc_slot}, (i == 0) ? 0 : 7);
      tick();
    end
    set_alloc(1'b0, '0, 1'b0, '0, 1'b0);
    set_wake(2, 6'd19);
    tick();
    clear_wake();
    check("t5_slot3", {29'd0, issue_slot}, 32'd3);
    check("t5_full_ready", {31'd0, alloc_ready}, 32'd0);
    set_alloc(1'b1, 6'd42, 1'b1, 6'd42, 1'b1);
    exp_q.push_back(3'd3);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("t5_count7", {28'd0, count}, 32'd7);
    check("t5_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    check("t5_alloc_slot3", {29'd0, alloc_slot}, 32'd3);
    tick();
    set_alloc(1'b0, '0, 1'b0, '0, 1'b0);
    check("t5_count8", {28'd0, count}, 32'd8);
    check("t5_new_ready", {29'd0, issue_slot}, 32'd3);

    // 6: flush overrides alloc and issue
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_pre_flush", {28'd0, count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b1, 6'($urandom_range(0, 63)), 1'b1, 6'($urandom_range(0, 63)), 1'b1);
      tick();
    end
    check("t6_count5", {28'd0, count}, 32'd5);
    flush = 1'b1;
    issue_ready = 1'b1;
    tick();
    flush = 1'b0;
    issue_ready = 1'b0;
    set_alloc(1'b0, '0, 1'b0, '0, 1'b0);
    check("t6_count", {28'd0, count}, 32'd0);
    check("t6_issue_valid", {31'd0, issue_valid}, 32'd0);
    check("t6_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    check("t6_alloc_slot", {29'd0, alloc_slot}, 32'd0);
    check("t6_empty", {31'd0, empty}, 32'd1);

    // ages after flush: both woken together, older goes first
    set_alloc(1'b1, 6'd60, 1'b0, 6'd0, 1'b1);
    tick();
    set_alloc(1'b1, 6'd61, 1'b0, 6'd0, 1'b1);
    tick();
    set_alloc(1'b0, '0, 1'b0, '0, 1'b0);
    set_wake(0, 6'd61);
    set_wake(1, 6'd60);
    tick();
    clear_wake();
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    issue_ready = 1'b1;
    tick(); tick();
    issue_ready = 1'b0;
    check("t7_count", {28'd0, count}, 32'd0);

    tick();
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
